// File: rtl/param_mem_reader.sv
// param_mem_reader: streams filter and image words from a synchronous-read
// memory into wide register buffers, one word per clock.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - load request, sampled only while idle
//   load_filt, load_img - select which phases run (sampled with start)
//   filt_base, img_base - base word addresses (sampled with start)
//   abort               - cancel an active load (MEM_READER_ABORT_EN only)
//   mem_rd_adr          - read address, 0 when no read is issued
//   mem_rd_data         - read data, valid the cycle after its address
//   busy, done          - not idle / one-cycle completion pulse
//   filters, img_data   - buffer contents, word k at bits [k*32 +: 32]
//
// Build option: define MEM_READER_ABORT_EN to make abort cancel a load.
// Without it the abort port is present but has no effect.
module param_mem_reader #(
    parameter int NUM_FILTERS  = 4,
    parameter int FILTER_WORDS = 4,
    parameter int IMG_WORDS    = 64,
    parameter int ADDR_W       = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   load_filt,
    input  logic                                   load_img,
    input  logic [ADDR_W-1:0]                      filt_base,
    input  logic [ADDR_W-1:0]                      img_base,
    input  logic                                   abort,
    output logic [ADDR_W-1:0]                      mem_rd_adr,
    input  logic [31:0]                            mem_rd_data,
    output logic                                   busy,
    output logic                                   done,
    output logic [NUM_FILTERS*FILTER_WORDS*32-1:0] filters,
    output logic [IMG_WORDS*32-1:0]                img_data
);

    localparam int FILT_TOTAL = NUM_FILTERS * FILTER_WORDS;
    localparam int MAX_WORDS  = (FILT_TOTAL > IMG_WORDS) ? FILT_TOTAL
                                                         : IMG_WORDS;
    localparam int CNT_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int FI_W  = (FILT_TOTAL > 1) ? $clog2(FILT_TOTAL) : 1;
    localparam int II_W  = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILT,
        S_IMG,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   fbase_q, fbase_d;
    logic [ADDR_W-1:0]   ibase_q, ibase_d;
    logic                do_img_q, do_img_d;
    logic                wr_vld_q, wr_vld_d;
    logic                wr_img_q, wr_img_d;
    logic [CNT_W-1:0]    wr_idx_q, wr_idx_d;

    logic [FILT_TOTAL-1:0][31:0] filt_q;
    logic [IMG_WORDS-1:0][31:0]  img_q;

    logic kill;
    logic wr_en;

`ifdef MEM_READER_ABORT_EN
    // Abort only bites while reads are outstanding; idle/done ignore it.
    assign kill = abort && (state_q == S_FILT ||
                            state_q == S_IMG  ||
                            state_q == S_FLUSH);
`else
    logic abort_unused;
    assign abort_unused = abort;
    assign kill         = 1'b0;
`endif

    // The word captured by the previous issue lands this edge unless
    // the load is being cancelled.
    assign wr_en = wr_vld_q && !kill;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fbase_d    = fbase_q;
        ibase_d    = ibase_q;
        do_img_d   = do_img_q;
        wr_vld_d   = 1'b0;
        wr_img_d   = wr_img_q;
        wr_idx_d   = wr_idx_q;
        mem_rd_adr = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    fbase_d  = filt_base;
                    ibase_d  = img_base;
                    do_img_d = load_img;
                    cnt_d    = '0;
                    if (load_filt) begin
                        state_d = S_FILT;
                    end else if (load_img) begin
                        state_d = S_IMG;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FILT: begin
                mem_rd_adr = fbase_q + ADDR_W'(cnt_q);
                wr_vld_d   = 1'b1;
                wr_img_d   = 1'b0;
                wr_idx_d   = cnt_q;
                if (cnt_q == CNT_W'(FILT_TOTAL - 1)) begin
                    cnt_d   = '0;
                    state_d = do_img_q ? S_IMG : S_FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IMG: begin
                mem_rd_adr = ibase_q + ADDR_W'(cnt_q);
                wr_vld_d   = 1'b1;
                wr_img_d   = 1'b1;
                wr_idx_d   = cnt_q;
                if (cnt_q == CNT_W'(IMG_WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (kill) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            wr_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            fbase_q  <= '0;
            ibase_q  <= '0;
            do_img_q <= 1'b0;
            wr_vld_q <= 1'b0;
            wr_img_q <= 1'b0;
            wr_idx_q <= '0;
            filt_q   <= '0;
            img_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fbase_q  <= fbase_d;
            ibase_q  <= ibase_d;
            do_img_q <= do_img_d;
            wr_vld_q <= wr_vld_d;
            wr_img_q <= wr_img_d;
            wr_idx_q <= wr_idx_d;
            if (wr_en) begin
                if (wr_img_q) begin
                    img_q[wr_idx_q[II_W-1:0]] <= mem_rd_data;
                end else begin
                    filt_q[wr_idx_q[FI_W-1:0]] <= mem_rd_data;
                end
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign filters  = filt_q;
    assign img_data = img_q;

endmodule

// File: doc/param_mem_reader.md
PARAM_MEM_READER -- requirements
Module: param_mem_reader

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 4: number of filter buffers.
REQ-002 SHALL have parameter FILTER_WORDS, default 4: 32-bit words per filter (16 bytes).
REQ-003 SHALL have parameter IMG_WORDS, default 64: 32-bit words in the image buffer (256 bytes).
REQ-004 SHALL have parameter ADDR_W, default 8: memory address width.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: load request, sampled only in IDLE.
REQ-008 SHALL have port load_filt, input, 1: include the filter phase; sampled with start.
REQ-009 SHALL have port load_img, input, 1: include the image phase; sampled with start.
REQ-010 SHALL have ports filt_base and img_base, input, ADDR_W each: base word addresses, sampled with start.
REQ-011 SHALL have port abort, input, 1: cancel the load (see Configuration).
REQ-012 SHALL have port mem_rd_adr, output, ADDR_W: memory read address.
REQ-013 SHALL have port mem_rd_data, input, 32: memory read data, valid one cycle after its address.
REQ-014 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port filters, output, NUM_FILTERS*FILTER_WORDS*32: filter bytes; filter f, word j at bits [(f*FILTER_WORDS+j)*32 +: 32].
REQ-017 SHALL have port img_data, output, IMG_WORDS*32: image bytes; word i at bits [i*32 +: 32].

Function
REQ-018 SHALL implement the FSM IDLE -> FILT -> IMG -> FLUSH -> DONE -> IDLE, skipping any phase whose load bit was 0.
REQ-019 SHALL leave IDLE on the edge where start=1; start seen in any other state SHALL be ignored.
REQ-020 SHALL, when start=1 with load_filt=load_img=0, go IDLE -> DONE, so done is high exactly 1 cycle after the start cycle.
REQ-021 SHALL, in FILT, issue one address per cycle, filt_base + f*FILTER_WORDS + j, with j incrementing first, for NUM_FILTERS*FILTER_WORDS cycles.
REQ-022 SHALL, in IMG, issue img_base + i, i = 0..IMG_WORDS-1, one per cycle, starting the cycle after the last FILT address.
REQ-023 SHALL compute addresses modulo 2^ADDR_W (wrap-around, no error).
REQ-024 SHALL write the mem_rd_data returned for each issued address into its destination word on the following edge. This is a one-stage pipeline; no bubbles between phases.
REQ-025 SHALL spend one cycle in FLUSH to write the final word, then one cycle in DONE with done=1.
REQ-026 SHALL give total latency N+2 cycles from the start edge to done=1, with N = total words loaded; defaults give 18 (filters only), 66 (image only) and 82 (both).
REQ-027 SHALL drive mem_rd_adr to 0 in IDLE, FLUSH and DONE.
REQ-028 SHALL leave buffers not selected by the load bits unchanged; they keep previous contents.
REQ-029 SHALL hold buffer contents after done until overwritten by a later load.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, force state IDLE and clear the address/word counters and the pipeline write-valid bit.
REQ-031 SHALL, under reset, clear the filters and img_data registers to 0, and set busy, done and mem_rd_adr to 0.
REQ-032 SHALL, on reset mid-load, discard the in-flight read; no write occurs on the reset edge, and done is not pulsed.

Configuration
REQ-033 SHALL support the macro MEM_READER_ABORT_EN.
REQ-034 SHALL, when MEM_READER_ABORT_EN is defined, respond to abort=1 in FILT, IMG or FLUSH: return to IDLE on the next edge without a done pulse, suppress the pending write, and keep buffer words already written.
REQ-035 SHALL, when MEM_READER_ABORT_EN is defined, ignore abort in IDLE and DONE.
REQ-036 SHALL, when MEM_READER_ABORT_EN is undefined, keep the abort port but ignore it entirely, and the load always runs to completion.

Verification
REQ-037 SHALL cover: defaults, memory[a]=a, start with filt_base=0x10, load_filt=1, load_img=0 -> addresses 0x10..0x1F on consecutive cycles; done at start+18; filter 2 word 1 = 0x19; img_data remains 0.
REQ-038 SHALL cover: both loads, filt_base=0x00, img_base=0x40 -> done at start+82; img_data word 63 = 0x7F; busy high for 82 cycles.
REQ-039 SHALL cover: image load with img_base=0xF0 -> address wraps 0xFF -> 0x00; img_data word 16 = 0x00.
REQ-040 SHALL cover: start with both load bits 0 -> done one cycle later; no buffer changes; start pulsed again while busy -> ignored.
REQ-041 SHALL cover: rst asserted 5 cycles into a filter load -> next cycle busy=0 and all outputs 0; no done pulse.
REQ-042 SHALL cover: with MEM_READER_ABORT_EN, abort 10 cycles into IMG -> IDLE next cycle, no done, words 0..8 written, word 9 onward unchanged; without the macro, the same stimulus completes with done.
